// File: rtl/store_lane_packer_pkg.sv
// Shared store-path definitions: size encodings, byte-enable constants and the
// packed lane bundle produced by the aligner and stored in the write FIFO.
package store_lane_packer_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_ALL = 4'b1111;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_lanes_t;

endpackage

// File: rtl/store_lane_packer_if.sv
// Store request channel from the MEM stage and write channel toward data memory.
interface store_lane_packer_if #(
    parameter int AW = 32
);

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic [1:0]    req_size;

    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/store_lane_packer_align.sv
// Combinational store packer: replicates sb/sh payload across byte lanes,
// builds byte enables and flags accesses that are not naturally aligned.
module store_lane_align
    import store_lane_packer_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_data,
    output st_lanes_t   o_lanes,
    output logic        o_misal
);

    always_comb begin
        o_lanes = '0;
        o_misal = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_lanes.wdata = {4{i_data[7:0]}};
                o_lanes.be    = 4'b0001 << i_addr_lo;
            end
            SZ_HALF: begin
                o_lanes.wdata = {2{i_data[15:0]}};
                o_lanes.be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misal       = i_addr_lo[0];
            end
            SZ_WORD: begin
                o_lanes.wdata = i_data;
                o_lanes.be    = BE_ALL;
                o_misal       = (i_addr_lo != 2'b00);
            end
            default: o_misal = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_lane_packer.sv
// Store lane packer: aligns MEM-stage stores onto the 32-bit data bus and
// queues them in a small FIFO drained to memory over valid/ready.
module store_lane_packer
    import store_lane_packer_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = 32,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    store_lane_packer_if.slave bus,
    output logic               misalign,
    output logic [AW-1:0]      bad_addr,
    output logic [PTRW:0]      count,
    output logic               empty,
    output logic               full
);

    typedef struct packed {
        logic [AW-1:0] addr;
        st_lanes_t     lanes;
    } entry_t;

    entry_t          r_fifo [DEPTH];
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [PTRW:0]   r_count;
    logic            r_misalign;
    logic [AW-1:0]   r_bad_addr;

    st_lanes_t w_lanes;
    logic      w_misal;
    logic      w_hs;
    logic      w_push;
    logic      w_pop;
    entry_t    w_entry;
    entry_t    w_head;

    store_lane_align u_align (
        .i_addr_lo (bus.req_addr[1:0]),
        .i_size    (bus.req_size),
        .i_data    (bus.req_data),
        .o_lanes   (w_lanes),
        .o_misal   (w_misal)
    );

    assign full  = (r_count == (PTRW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    // Rejected stores still complete the handshake so MEM never stalls on them.
    assign bus.req_ready = !full;
    assign w_hs          = bus.req_valid && bus.req_ready;
    assign w_push        = w_hs && !w_misal;
    assign w_pop         = bus.mem_valid && bus.mem_ready;

    assign w_entry.addr  = {bus.req_addr[AW-1:2], 2'b00};
    assign w_entry.lanes = w_lanes;
    assign w_head        = r_fifo[r_rd_ptr];

    assign bus.mem_valid = !empty;
    assign bus.mem_addr  = w_head.addr;
    assign bus.mem_wdata = w_head.lanes.wdata;
    assign bus.mem_be    = w_head.lanes.be;

    assign misalign = r_misalign;
    assign bad_addr = r_bad_addr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTRW+1)'(1);
                2'b01:   r_count <= r_count - (PTRW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
            r_bad_addr <= '0;
        end else begin
            r_misalign <= w_hs && w_misal;
            if (w_hs && w_misal) r_bad_addr <= bus.req_addr;
        end
    end

endmodule

// File: tb/tb_store_lane_packer.sv
// Bench for store_lane_packer: directed scenarios plus random stores, checked by
// a scoreboard fed from an arithmetic reference model of the store rules.
module tb_store_lane_packer;
    import store_lane_packer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        misalign;
    logic [31:0] bad_addr;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    store_lane_packer_if #(.AW(32)) bus ();

    store_lane_packer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .misalign (misalign),
        .bad_addr (bad_addr),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t        exp_q[$];
    int          n_tot = 0;
    int          n_fail = 0;
    logic        rej_pend = 1'b0;
    logic [31:0] mdl_bad = '0;
    logic        stall_prev = 1'b0;
    ent_t        prev_out;
    bit          rnd_run = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tot++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: naturally aligned access of 2^size bytes, payload replicated
    // by multiplication, enables a run of 2^size ones shifted to the byte offset.
    function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] sz, output logic bad, output ent_t e);
        int nb;
        int ofs;
        nb  = 1 << sz;
        ofs = int'(a % 4);
        bad = (sz == 2'b11) || ((a % nb) != 0);
        e.addr = a - (a % 4);
        if (nb == 1)      e.wdata = 32'(d[7:0]) * 32'h01010101;
        else if (nb == 2) e.wdata = 32'(d[15:0]) * 32'h00010001;
        else              e.wdata = d;
        e.be = 4'(((1 << nb) - 1) << ofs);
    endfunction

    always @(negedge clk) begin
        ent_t e;
        logic bad;
        if (!rst_n) begin
            exp_q.delete();
            rej_pend   = 1'b0;
            mdl_bad    = '0;
            stall_prev = 1'b0;
        end else begin
            chk("count",     64'(count),         64'(exp_q.size()));
            chk("empty",     64'(empty),         64'(exp_q.size() == 0));
            chk("full",      64'(full),          64'(exp_q.size() == DEPTH));
            chk("req_ready", 64'(bus.req_ready), 64'(exp_q.size() < DEPTH));
            chk("mem_valid", 64'(bus.mem_valid), 64'(exp_q.size() != 0));
            chk("misalign",  64'(misalign),      64'(rej_pend));
            chk("bad_addr",  64'(bad_addr),      64'(mdl_bad));
            if (stall_prev) begin
                chk("stable_addr",  64'(bus.mem_addr),  64'(prev_out.addr));
                chk("stable_wdata", 64'(bus.mem_wdata), 64'(prev_out.wdata));
                chk("stable_be",    64'(bus.mem_be),    64'(prev_out.be));
            end
            stall_prev = 1'b0;
            if (exp_q.size() != 0 && bus.mem_valid) begin
                chk("mem_addr",  64'(bus.mem_addr),  64'(exp_q[0].addr));
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_q[0].wdata));
                chk("mem_be",    64'(bus.mem_be),    64'(exp_q[0].be));
                prev_out   = exp_q[0];
                stall_prev = !bus.mem_ready;
                if (bus.mem_ready) void'(exp_q.pop_front());
            end
            rej_pend = 1'b0;
            if (bus.req_valid && bus.req_ready) begin
                model(bus.req_addr, bus.req_data, bus.req_size, bad, e);
                if (bad) begin
                    rej_pend = 1'b1;
                    mdl_bad  = bus.req_addr;
                end else begin
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int waited;
        waited = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = sz;
        @(negedge clk);
        while (!bus.req_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            n_tot++;
            n_fail++;
            $display("FAIL store_timeout: addr %0h never accepted, expected acceptance within 200 cycles", a);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          waited;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = '0;
        bus.mem_ready = 1'b0;

        #1;
        chk("rst_count",     64'(count),         64'd0);
        chk("rst_empty",     64'(empty),         64'd1);
        chk("rst_full",      64'(full),          64'd0);
        chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("rst_misalign",  64'(misalign),      64'd0);
        chk("rst_bad_addr",  64'(bad_addr),      64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Byte store at the top lane, visible the cycle after acceptance
        bus.mem_ready = 1'b1;
        do_store(32'h0000_1003, 32'hAABBCCDD, SZ_BYTE);
        chk("sb_valid", 64'(bus.mem_valid), 64'd1);
        chk("sb_addr",  64'(bus.mem_addr),  64'h1000);
        chk("sb_wdata", 64'(bus.mem_wdata), 64'hDDDDDDDD);
        chk("sb_be",    64'(bus.mem_be),    64'b1000);
        @(posedge clk);
        #1;
        chk("sb_drained", 64'(empty), 64'd1);

        do_store(32'h0000_2002, 32'h12345678, SZ_HALF);
        chk("sh_wdata", 64'(bus.mem_wdata), 64'h56785678);
        chk("sh_be",    64'(bus.mem_be),    64'b1100);
        do_store(32'h0000_2004, 32'hCAFEF00D, SZ_WORD);
        chk("sw_be", 64'(bus.mem_be), 64'b1111);
        repeat (2) @(posedge clk);
        #1;

        // Rejected stores: single pulses, then back-to-back rejects
        do_store(32'h0000_3001, 32'h1, SZ_WORD);
        chk("mis_w_pulse", 64'(misalign),      64'd1);
        chk("mis_w_addr",  64'(bad_addr),      64'h3001);
        chk("mis_w_count", 64'(count),         64'd0);
        chk("mis_w_valid", 64'(bus.mem_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("mis_w_once", 64'(misalign), 64'd0);
        do_store(32'h0000_3005, 32'h2, SZ_HALF);
        chk("mis_h_pulse", 64'(misalign), 64'd1);
        chk("mis_h_addr",  64'(bad_addr), 64'h3005);
        do_store(32'h0000_3002, 32'h3, SZ_WORD);
        do_store(32'h0000_3003, 32'h4, 2'b11);
        chk("mis_b2b_addr", 64'(bad_addr), 64'h3003);
        @(posedge clk);
        #1;

        // Fill to full with memory stalled; fifth store waits for a pop
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_store(32'h4000 + 32'(4 * i), 32'h4000_0000 + 32'(i), SZ_WORD);
        chk("fill_full",  64'(full),          64'd1);
        chk("fill_ready", 64'(bus.req_ready), 64'd0);
        fork
            do_store(32'h0000_4010, 32'h4000_0004, SZ_WORD);
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("fill_held", 64'(count), 64'd4);
        bus.mem_ready = 1'b1;
        wait fork;
        repeat (6) @(posedge clk);
        #1;
        chk("fill_drained", 64'(empty), 64'd1);

        // Streaming at one store per cycle, pointers wrap several times
        for (int i = 0; i < 10; i++) begin
            do_store(32'h5000 + 32'(4 * i), $urandom(), SZ_WORD);
            chk("stream_count", 64'(count), 64'd1);
        end
        @(posedge clk);
        #1;
        chk("stream_empty", 64'(empty), 64'd1);

        // Asynchronous reset mid-cycle with entries queued
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_store(32'h6000 + 32'(4 * i), 32'h60 + 32'(i), SZ_WORD);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count),         64'd0);
        chk("arst_valid", 64'(bus.mem_valid), 64'd0);
        chk("arst_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        do_store(32'h0000_6008, 32'h11223344, SZ_WORD);
        chk("post_rst_valid", 64'(bus.mem_valid), 64'd1);
        chk("post_rst_addr",  64'(bus.mem_addr),  64'h6008);
        chk("post_rst_wdata", 64'(bus.mem_wdata), 64'h11223344);
        @(posedge clk);
        #1;

        // Random stores with random memory back-pressure
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    a  = $urandom();
                    sz = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
                    do_store(a, $urandom(), sz);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    @(posedge clk);
                    #1;
                    bus.mem_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.mem_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        #1;
        chk("final_drain", 64'(exp_q.size()), 64'd0);
        chk("final_empty", 64'(empty), 64'd1);

        $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
        $finish;
    end

endmodule

// File: doc/store_lane_packer.md
Name: store_lane_packer

Overview:
- Store-side counterpart to the load-path sign/zero extender: narrows sb/sh/sw store data onto the 32-bit data-memory bus.
- Per store: computes byte lanes and byte-enables, detects misalignment, and queues the packed write in a small FIFO.
- Drains the FIFO to data memory over a valid/ready handshake.
- Sits between the MEM pipeline stage and the data memory; back-pressures MEM when full.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of two, ≥2.
- AW, 32: address width.
- PTRW, $clog2(DEPTH): pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a store.
- req_ready  out  1  block can accept a store this cycle.
- req_addr  in  AW  byte address of the store.
- req_data  in  32  rt register value (payload in low bits).
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_valid  out  1  FIFO head is valid toward memory.
- mem_ready  in  1  memory accepts the head this cycle.
- mem_addr  out  AW  word-aligned address, {addr[AW-1:2],2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables; bit i selects bits [8i+7:8i].
- misalign  out  1  one-cycle pulse for a rejected store.
- bad_addr  out  AW  address of the last rejected store; holds until the next rejection.
- count  out  PTRW+1  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, count = 0.
  - empty=1, full=0, mem_valid=0, misalign=0, bad_addr=0.
  - req_ready=1.
  - Any in-flight or queued stores are discarded.
- Accept: a handshake is req_valid && req_ready. req_ready = !full (combinational). No same-cycle bypass of a full FIFO, even if mem_ready=1.
- Packing (combinational on the request, written into the FIFO on the handshake edge):
  - byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, be = addr[1] ? 1100 : 0011.
  - word: wdata=d, be=1111.
- Misalignment:
  - Rejected cases: half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - The store is still handshaken but is not enqueued.
  - Next cycle: misalign=1 for exactly one cycle, and bad_addr=req_addr registered.
  - Back-to-back rejects give consecutive pulses, with bad_addr updating each cycle.
- Latency: an entry accepted at edge N is visible on mem_* after edge N (mem_valid high in cycle N+1) when the FIFO was empty.
- Drain:
  - mem_* are driven from the FIFO head register.
  - On mem_valid && mem_ready, rd_ptr increments.
  - mem_addr, mem_wdata and mem_be are stable while mem_valid=1 and mem_ready=0.
- Ordering: strict FIFO; memory sees stores in program order.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pop with no push: count−1. Push with no pop: count+1.
- Pointers wrap modulo DEPTH. count is the authoritative full/empty source.
- mem_valid = !empty.
- A misaligned request arriving in the same cycle as a pop decrements count only.
- No flush input: stores reaching this block are committed.
- State machine per entry is implicit: EMPTY → VALID on push, VALID → EMPTY on pop. Block-level state is {count, wr_ptr, rd_ptr}.

Decomposition:
- Shared package (mips_mem_pkg):
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - BE_ALL=4'b1111.
  - a packed store-entry typedef {addr, wdata, be}.
- Natural sub-module: store_lane_align, a pure combinational packer producing wdata, be and the misalign flag.
- The top level holds the FIFO storage, pointers, count and the misalign/bad_addr registers.

Test Plan:
- sb, addr=0x1003, data=0xAABBCCDD, mem_ready=1 → next cycle: mem_addr=0x1000, mem_wdata=0xDDDDDDDD, mem_be=1000; then empty=1.
- sh, addr=0x2002, data=0x12345678 → mem_wdata=0x56785678, mem_be=1100. Then sw, addr=0x2004, data=0xCAFEF00D → mem_be=1111, in order.
- sw at 0x3001, and separately sh at 0x3005 → each gives misalign=1 for one cycle with bad_addr=0x3001 then 0x3005; count stays 0; mem_valid stays 0.
- mem_ready=0, push 5 word stores with DEPTH=4 → full=1 and req_ready=0 after the 4th; 5th held until a pop. Raise mem_ready → 4 stores drained in order with stable outputs, then the 5th.
- Continuous push and pop at 1/cycle for 10 cycles → count constant at 1; pointers wrap past DEPTH without loss or duplication.
- rst_n asserted low mid-cycle with 3 entries queued → immediately count=0, mem_valid=0, req_ready=1; after release the first new store appears next cycle.
